// File: rtl/mips_bus_memory_if.sv
// CPU memory-bus bundle between a master and the mips_bus_memory responder.
// The master holds every request signal stable while waitrequest is high.
interface mips_bus_memory_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_bus_memory.sv
// Word-addressed RAM bus responder with programmable wait states, byte-lane
// writes, out-of-range/protocol error detection and a sticky err flag.
module mips_bus_memory #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_memory_if.slave   bus,
  output logic               err
);

  localparam int unsigned Words    = 1 << ADDR_WIDTH;
  localparam logic [7:0]  WaitInit = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  logic [31:0] mem [Words];

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  rd_q, wr_q, bad_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           readdata_q, readdata_d;
  logic                  err_q, err_d;

  logic [31:0]           off;
  logic                  in_range, req, bad_new, start;
  logic [ADDR_WIDTH-1:0] sel_idx;
  logic                  sel_ok;

  assign off      = bus.address - BASE_ADDR;
  assign in_range = (bus.address >= BASE_ADDR) && (off[31:ADDR_WIDTH+2] == '0);
  assign req      = bus.read | bus.write;
  assign bad_new  = ~in_range | (bus.read & bus.write);
  assign start    = (state_q == StIdle) & req;

  logic unused_off;
  assign unused_off = ^off[1:0];

  // With zero wait states ACK is entered straight from IDLE, before anything is latched.
  assign sel_idx = (state_q == StIdle) ? off[ADDR_WIDTH+1:2] : idx_q;
  assign sel_ok  = (state_q == StIdle) ? (bus.read & ~bad_new) : (rd_q & ~bad_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    readdata_d = readdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES > 0) ? StWait : StAck;
          if (bad_new) err_d = 1'b1;
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StAck && state_q != StAck) begin
      readdata_d = sel_ok ? mem[sel_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h0;
      idx_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      bad_q      <= 1'b0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
      if (start) begin
        idx_q   <= off[ADDR_WIDTH+1:2];
        rd_q    <= bus.read;
        wr_q    <= bus.write;
        bad_q   <= bad_new;
        wdata_q <= bus.writedata;
        be_q    <= bus.byteenable;
      end
    end
  end

  // Write commits on the edge that ends ACK; reset forces IDLE so it drops the write.
  always_ff @(posedge clk) begin
    if (state_q == StAck && wr_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.waitrequest = req & (state_q != StAck);
  assign err             = err_q;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Bench for mips_bus_memory: directed vector tables, randomized traffic against
// a word-array model, and hand sequences for abort, reset and zero-wait cases.
module tb_mips_bus_memory;

  localparam logic [31:0] Base = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset;
  logic err2, err0;

  always #5 clk = ~clk;

  mips_bus_memory_if bus2 ();
  mips_bus_memory_if bus0 ();

  mips_bus_memory #(
    .ADDR_WIDTH (10),
    .BASE_ADDR  (Base),
    .WAIT_CYCLES(2),
    .INIT_FILE  ("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2),
    .err  (err2)
  );

  mips_bus_memory #(
    .ADDR_WIDTH (10),
    .BASE_ADDR  (Base),
    .WAIT_CYCLES(0),
    .INIT_FILE  ("")
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0),
    .err  (err0)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one transaction on the WAIT_CYCLES=2 port; lat counts clock edges to completion.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output int lat);
    @(negedge clk);
    bus2.read = rd; bus2.write = wr; bus2.address = addr;
    bus2.writedata = wdata; bus2.byteenable = be;
    #1;
    lat = 0;
    while (bus2.waitrequest !== 1'b0 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    rdata = bus2.readdata;
    bus2.read = 1'b0; bus2.write = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] rdata;
    int lat;
    txn(v.rd, v.wr, v.addr, v.wdata, v.be, rdata, lat);
    check({tag, " latency"}, 32'(lat), 32'd3);
    if (v.chk_rd) check({tag, " rdata"}, rdata, v.exp_rdata);
    check({tag, " err"}, {31'h0, err2}, {31'h0, v.exp_err});
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input bit chk, input logic [31:0] exp, input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.chk_rd = chk; v.exp_rdata = exp; v.exp_err = eerr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t clean [$];
    vec_t errs [$];
    logic [31:0] rdata;
    int lat;

    bus2.read = 0; bus2.write = 0; bus2.address = 0; bus2.writedata = 0; bus2.byteenable = 0;
    bus0.read = 0; bus0.write = 0; bus0.address = 0; bus0.writedata = 0; bus0.byteenable = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset readdata", bus2.readdata, 32'h0);
    check("reset err", {31'h0, err2}, 32'h0);
    check("reset waitrequest", {31'h0, bus2.waitrequest}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    clean.push_back(mk(0, 1, Base + 32'h0,  32'h24020005, 4'hF, 0, 32'h0, 0));
    clean.push_back(mk(0, 1, Base + 32'h4,  32'h00000000, 4'hF, 0, 32'h0, 0));
    clean.push_back(mk(0, 1, Base + 32'h8,  32'h11223344, 4'hF, 0, 32'h0, 0));
    clean.push_back(mk(0, 1, Base + 32'h10, 32'h55AA55AA, 4'hF, 0, 32'h0, 0));
    clean.push_back(mk(1, 0, Base + 32'h0,  32'h0,        4'h0, 1, 32'h24020005, 0));
    clean.push_back(mk(0, 1, Base + 32'h8,  32'hDEADBEEF, 4'h5, 0, 32'h0, 0));
    clean.push_back(mk(1, 0, Base + 32'h8,  32'h0,        4'hF, 1, 32'h11AD33EF, 0));
    clean.push_back(mk(0, 1, Base + 32'h8,  32'hFFFFFFFF, 4'h0, 0, 32'h0, 0));
    clean.push_back(mk(1, 0, Base + 32'hB,  32'h0,        4'h0, 1, 32'h11AD33EF, 0));
    clean.push_back(mk(0, 1, Base + 32'h8,  32'hCAFEF00D, 4'hA, 0, 32'h0, 0));
    clean.push_back(mk(1, 0, Base + 32'h8,  32'h0,        4'h3, 1, 32'hCAADF0EF, 0));
    clean.push_back(mk(1, 0, Base + 32'h12, 32'h0,        4'h0, 1, 32'h55AA55AA, 0));
    foreach (clean[i]) run_vec(clean[i], $sformatf("vec%0d", i));

    // Randomized traffic on words 16..31, all preloaded so the model is fully known.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      txn(0, 1, Base + 32'(4 * (16 + i)), model[i], 4'hF, rdata, lat);
    end
    for (int i = 0; i < 150; i++) begin
      int unsigned idx = $urandom_range(0, 15);
      bit rd = 1'($urandom_range(0, 1));
      logic [3:0] be = 4'($urandom_range(0, 15));
      logic [31:0] d = $urandom;
      logic [31:0] a = Base + 32'(4 * (16 + idx)) + 32'($urandom_range(0, 3));
      txn(rd, !rd, a, d, be, rdata, lat);
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd3);
      if (rd) check($sformatf("rand%0d rdata", i), rdata, model[idx]);
      else model[idx] = merge(model[idx], d, be);
    end
    check("rand err", {31'h0, err2}, 32'h0);

    // Address changed mid-transaction must be ignored.
    @(negedge clk);
    bus2.read = 1; bus2.address = Base; bus2.byteenable = 4'hF;
    @(negedge clk);
    bus2.address = Base + 32'h10;
    lat = 1;
    #1;
    while (bus2.waitrequest !== 1'b0 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    check("latched addr rdata", bus2.readdata, 32'h24020005);
    check("latched addr latency", 32'(lat), 32'd3);
    bus2.read = 0;

    // Zero-wait port: load word0, then hold read across two transactions.
    @(negedge clk);
    bus0.write = 1; bus0.address = Base; bus0.writedata = 32'h24020005; bus0.byteenable = 4'hF;
    #1;
    check("w0 write waitrequest", {31'h0, bus0.waitrequest}, 32'h1);
    @(negedge clk); #1;
    check("w0 write done", {31'h0, bus0.waitrequest}, 32'h0);
    bus0.write = 0;
    @(negedge clk);
    bus0.read = 1; bus0.address = Base;
    #1;
    check("w0 start waitrequest", {31'h0, bus0.waitrequest}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("w0 hold wr%0d", k), {31'h0, bus0.waitrequest}, {31'h0, k[0]});
      if (!k[0]) check($sformatf("w0 hold rdata%0d", k), bus0.readdata, 32'h24020005);
    end
    bus0.read = 0;
    check("w0 err", {31'h0, err0}, 32'h0);

    // Error cases; err becomes sticky from the first one.
    errs.push_back(mk(1, 0, 32'h00000000, 32'h0,        4'hF, 1, 32'h0, 1));
    errs.push_back(mk(1, 0, Base + 32'h0, 32'h0,        4'hF, 1, 32'h24020005, 1));
    errs.push_back(mk(1, 0, Base + 32'h1000, 32'h0,     4'hF, 1, 32'h0, 1));
    errs.push_back(mk(0, 1, Base + 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1));
    errs.push_back(mk(1, 0, Base + 32'h0, 32'h0,        4'hF, 1, 32'h24020005, 1));
    errs.push_back(mk(1, 1, Base + 32'h10, 32'h0,       4'hF, 1, 32'h0, 1));
    errs.push_back(mk(1, 0, Base + 32'h10, 32'h0,       4'hF, 1, 32'h55AA55AA, 1));
    foreach (errs[i]) run_vec(errs[i], $sformatf("err%0d", i));

    // Master drops a write during WAIT: aborted, memory unchanged.
    @(negedge clk);
    bus2.write = 1; bus2.address = Base; bus2.writedata = 32'hFFFFFFFF; bus2.byteenable = 4'hF;
    @(negedge clk);
    bus2.write = 0;
    #1;
    check("abort waitrequest", {31'h0, bus2.waitrequest}, 32'h0);
    txn(1, 0, Base, 32'h0, 4'hF, rdata, lat);
    check("abort readback", rdata, 32'h24020005);
    check("abort readback latency", 32'(lat), 32'd3);

    // Reset during WAIT of a write: write discarded, outputs and err cleared.
    @(negedge clk);
    bus2.write = 1; bus2.address = Base + 32'h4; bus2.writedata = 32'h12345678; bus2.byteenable = 4'hF;
    @(negedge clk);
    bus2.write = 0;
    reset = 1'b1;
    #1;
    check("rst waitrequest", {31'h0, bus2.waitrequest}, 32'h0);
    check("rst readdata", bus2.readdata, 32'h0);
    check("rst err", {31'h0, err2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    txn(1, 0, Base + 32'h4, 32'h0, 4'hF, rdata, lat);
    check("rst readback", rdata, 32'h0);
    check("rst readback latency", 32'(lat), 32'd3);
    check("rst err after", {31'h0, err2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
